// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the synchronous FIFO family.
// Status flags are bundled so the top drives every status output from one place.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic bit is_pow2(input int unsigned value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage array: one clocked write port, one combinational read port.
// Contents are intentionally not reset.
module sync_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO: pointers with wrap bit, occupancy count, threshold flags,
// synchronous flush, sticky overflow/underflow and optional first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic [CW-1:0]     o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_depth_check
        $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
    end

    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic [CW-1:0]       r_count;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_overflow;
    logic                r_underflow;
    logic [DATA_W-1:0]   w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_pop_ok;
    logic                w_push_ok;
    fifo_status_t        w_status;

    // Full when indices match but wrap bits differ
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]});
    assign w_pop_ok  = i_pop & ~w_empty;
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push_ok),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (i_wdata),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_head)
    );

    // Pointers, occupancy, registered read data and sticky error flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr      <= {(AW+1){1'b0}};
            r_rptr      <= {(AW+1){1'b0}};
            r_count     <= {CW{1'b0}};
            r_rdata     <= {DATA_W{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_wptr      <= {(AW+1){1'b0}};
            r_rptr      <= {(AW+1){1'b0}};
            r_count     <= {CW{1'b0}};
            r_rdata     <= {DATA_W{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop_ok) begin
                r_rptr  <= r_rptr + {{AW{1'b0}}, 1'b1};
                r_rdata <= w_head;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
            r_overflow  <= r_overflow | (i_push & w_full & ~w_pop_ok);
            r_underflow <= r_underflow | (i_pop & w_empty);
        end
    end

    // Status bundle derived from registered state
    always_comb begin
        w_status              = '0;
        w_status.full         = w_full;
        w_status.empty        = w_empty;
        w_status.almost_full  = (r_count >= AFULL_C);
        w_status.almost_empty = (r_count <= AEMPTY_C);
        w_status.overflow     = r_overflow;
        w_status.underflow    = r_underflow;
    end

    assign o_full         = w_status.full;
    assign o_empty        = w_status.empty;
    assign o_almost_full  = w_status.almost_full;
    assign o_almost_empty = w_status.almost_empty;
    assign o_overflow     = w_status.overflow;
    assign o_underflow    = w_status.underflow;
    assign o_count        = r_count;

    // Fall-through output is forced to zero while empty so it never exposes stale storage
    assign o_rdata = (FWFT != 0) ? (w_empty ? {DATA_W{1'b0}} : w_head) : r_rdata;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a registered-read and a fall-through FIFO driven in lockstep,
// both compared against a queue-based reference model.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rd0, rd1;
    logic [2:0] cnt0, cnt1;
    logic full0, empty0, af0, ae0, ovf0, udf0;
    logic full1, empty1, af1, ae1, ovf1, udf1;
    logic [8:0] st0, st1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_rd0 = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(4), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)) u_fwft0 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_push(push), .i_wdata(wdata), .i_pop(pop),
        .o_rdata(rd0), .o_full(full0), .o_empty(empty0), .o_almost_full(af0),
        .o_almost_empty(ae0), .o_count(cnt0), .o_overflow(ovf0), .o_underflow(udf0));

    sync_fifo_param #(.DATA_W(8), .DEPTH(4), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)) u_fwft1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_push(push), .i_wdata(wdata), .i_pop(pop),
        .o_rdata(rd1), .o_full(full1), .o_empty(empty1), .o_almost_full(af1),
        .o_almost_empty(ae1), .o_count(cnt1), .o_overflow(ovf1), .o_underflow(udf1));

    assign st0 = {cnt0, full0, empty0, af0, ae0, ovf0, udf0};
    assign st1 = {cnt1, full1, empty1, af1, ae1, ovf1, udf1};

    function automatic logic [8:0] exp_st();
        int n;
        n = m_q.size();
        return {3'(n), n == 4, n == 0, n >= 3, n <= 1, m_ovf, m_udf};
    endfunction

    function automatic logic [7:0] exp_head();
        return (m_q.size() > 0) ? m_q[0] : 8'h00;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rd0 = 8'h00;
    endtask

    task automatic model_step(input bit p, input bit q, input bit f, input logic [7:0] d);
        bit pop_ok, push_ok;
        if (f) begin
            model_reset();
        end else begin
            pop_ok  = q && (m_q.size() > 0);
            push_ok = p && ((m_q.size() < 4) || pop_ok);
            if (q && m_q.size() == 0) m_udf = 1'b1;
            if (p && m_q.size() == 4 && !pop_ok) m_ovf = 1'b1;
            if (pop_ok) m_rd0 = m_q.pop_front();
            if (push_ok) m_q.push_back(d);
        end
    endtask

    task automatic drive_cycle(input bit p, input bit q, input bit f, input logic [7:0] d);
        push = p; pop = q; flush = f; wdata = d;
        @(posedge clk);
        model_step(p, q, f, d);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h11);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h22);
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_tests++;
        if (rd0 !== 8'h11 || udf0 !== 1'b1) begin
            $display("FAIL reset_pre: rd0=%h udf0=%b, need 11/1", rd0, udf0); n_fail++;
        end
        rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (st0 !== 9'b000_0_1_0_1_0_0 || st1 !== 9'b000_0_1_0_1_0_0) begin
            $display("FAIL reset_status: st0=%b st1=%b, need 000010100", st0, st1); n_fail++;
        end
        n_tests++;
        if (rd0 !== 8'h00 || rd1 !== 8'h00) begin
            $display("FAIL reset_rdata: rd0=%h rd1=%h, need 00", rd0, rd1); n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [7:0] e;
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            e = 8'hA1 + 8'(i);
            drive_cycle(1'b1, 1'b0, 1'b0, e);
            n_tests++;
            if (cnt0 !== 3'(i + 1) || st0 !== exp_st() || st1 !== exp_st()) begin
                $display("FAIL fill_%0d: st0=%b st1=%b, need %b", i, st0, st1, exp_st()); n_fail++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            e = 8'hA1 + 8'(i);
            n_tests++;
            if (rd1 !== e) begin
                $display("FAIL drain_fwft_%0d: rd1=%h, need %h", i, rd1, e); n_fail++;
            end
            drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            n_tests++;
            if (rd0 !== e || st0 !== exp_st() || st1 !== exp_st()) begin
                $display("FAIL drain_reg_%0d: rd0=%h st0=%b, need %h %b", i, rd0, st0, e, exp_st()); n_fail++;
            end
        end
        n_tests++;
        if (empty0 !== 1'b1 || empty1 !== 1'b1) begin
            $display("FAIL drain_empty: empty0=%b empty1=%b, need 1", empty0, empty1); n_fail++;
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] e;
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'hA1 + 8'(i));
        drive_cycle(1'b1, 1'b1, 1'b0, 8'hB5);
        n_tests++;
        if (rd0 !== 8'hA1 || cnt0 !== 3'd4 || ovf0 !== 1'b0 || st1 !== exp_st()) begin
            $display("FAIL full_push_pop: rd0=%h cnt0=%0d ovf0=%b st1=%b", rd0, cnt0, ovf0, st1); n_fail++;
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'hB6);
        n_tests++;
        if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || cnt0 !== 3'd4) begin
            $display("FAIL overflow: ovf0=%b ovf1=%b cnt0=%0d, need 1 1 4", ovf0, ovf1, cnt0); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            e = (i == 3) ? 8'hB5 : 8'hA2 + 8'(i);
            n_tests++;
            if (rd1 !== e) begin
                $display("FAIL ovf_drain_fwft_%0d: rd1=%h, need %h", i, rd1, e); n_fail++;
            end
            drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            n_tests++;
            if (rd0 !== e) begin
                $display("FAIL ovf_drain_reg_%0d: rd0=%h, need %h", i, rd0, e); n_fail++;
            end
        end
    endtask

    task automatic test_empty_pop();
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_tests++;
        if (udf0 !== 1'b1 || udf1 !== 1'b1 || cnt0 !== 3'd0 || st0 !== exp_st()) begin
            $display("FAIL underflow: st0=%b st1=%b, need %b", st0, st1, exp_st()); n_fail++;
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h5C);
        n_tests++;
        if (cnt0 !== 3'd1 || cnt1 !== 3'd1 || rd1 !== 8'h5C) begin
            $display("FAIL push_pop_empty: cnt0=%0d rd1=%h, need 1 5c", cnt0, rd1); n_fail++;
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_tests++;
        if (rd0 !== 8'h5C || st0 !== exp_st()) begin
            $display("FAIL push_pop_empty_head: rd0=%h, need 5c", rd0); n_fail++;
        end
    endtask

    task automatic test_wrap();
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 8'(i));
            n_tests++;
            if (rd1 !== 8'(i)) begin
                $display("FAIL wrap_fwft_%0d: rd1=%h, need %h", i, rd1, 8'(i)); n_fail++;
            end
            drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            n_tests++;
            if (rd0 !== 8'(i) || st0 !== exp_st()) begin
                $display("FAIL wrap_reg_%0d: rd0=%h, need %h", i, rd0, 8'(i)); n_fail++;
            end
        end
    endtask

    task automatic test_flush();
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_tests++;
        if (st0 !== 9'b011_0_0_1_0_1_1) begin
            $display("FAIL flush_pre: st0=%b, need 011001011", st0); n_fail++;
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 8'hEE);
        n_tests++;
        if (st0 !== 9'b000_0_1_0_1_0_0 || st1 !== 9'b000_0_1_0_1_0_0 || rd0 !== 8'h00) begin
            $display("FAIL flush: st0=%b st1=%b rd0=%h, need 000010100 00", st0, st1, rd0); n_fail++;
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h77);
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_tests++;
        if (rd0 !== 8'h77 || st0 !== exp_st()) begin
            $display("FAIL flush_absent: rd0=%h, need 77", rd0); n_fail++;
        end
    endtask

    task automatic test_random();
        bit p, q, f;
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 9) < 6);
            q = ($urandom_range(0, 9) < 5);
            f = ($urandom_range(0, 39) == 0);
            drive_cycle(p, q, f, 8'($urandom));
            n_tests++;
            if (st0 !== exp_st() || st1 !== exp_st()) begin
                $display("FAIL rand_status_%0d: st0=%b st1=%b, need %b", i, st0, st1, exp_st()); n_fail++;
            end
            n_tests++;
            if (rd0 !== m_rd0 || rd1 !== exp_head()) begin
                $display("FAIL rand_rdata_%0d: rd0=%h rd1=%h, need %h %h", i, rd0, rd1, m_rd0, exp_head());
                n_fail++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_empty_pop();
        test_wrap();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
